// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and defaults for the multi-channel clock gate controller.
// Per-channel gate FSM states and a helper that maps a state to its gate enable.
package clk_gate_ctrl_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        HOLD = 2'd3
    } gate_state_e;

    function automatic logic gate_open(gate_state_e s);
        return s != OFF;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Per-channel gating bundle between subsystem requesters and the gate controller.
// master = subsystem side, slave = controller side.
interface clk_gate_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] ena;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] wake_req;
    logic [NUM_CH-1:0] wake_ack;
    logic [NUM_CH-1:0] gate_en;
    logic [NUM_CH-1:0] clk_g;

    modport master (
        output ena,
        output busy,
        output wake_req,
        input  wake_ack,
        input  gate_en,
        input  clk_g
    );

    modport slave (
        input  ena,
        input  busy,
        input  wake_req,
        output wake_ack,
        output gate_en,
        output clk_g
    );
endinterface

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: enable captured by a low-phase transparent latch, then ANDed with the clock.
// Behavioural stand-in for the library ICG cell.
module clk_gate_cell (
    input  logic clk_i,
    input  logic ena_i,
    input  logic test_en_i,
    output logic clk_o
);
    logic en_l;

    // Latch is closed while clk_i is high, so enable changes cannot chop a high phase.
    always_latch begin
        if (!clk_i) begin
            en_l <= ena_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_l;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock gate controller: per-channel gate FSM with idle hysteresis,
// 4-phase wake handshake and one gate cell per channel.
//
// state | meaning
// ------+-----------------------------------------------------------
// OFF   | gate closed, waiting for busy or wake request
// WAKE  | gate opening, one cycle before the channel counts as ON
// ON    | gate open, channel active; wake requests are acknowledged
// HOLD  | gate open, channel idle; counting down cfg_idle_i+1 cycles
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 test_en_i,
    input  logic [CNT_W-1:0]     cfg_idle_i,
    clk_gate_ctrl_if.slave       bus
);

    logic [NUM_CH-1:0] ack_vec;
    logic [NUM_CH-1:0] gate_vec;
    logic [NUM_CH-1:0] clk_vec;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        gate_state_e      state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             ack_q, ack_d;
        logic             active;

        always_comb begin
            active  = bus.busy[g] | bus.wake_req[g];
            state_d = state_q;
            cnt_d   = cnt_q;

            // ena low overrides every other condition in every state
            if (!bus.ena[g]) begin
                state_d = OFF;
            end else begin
                unique case (state_q)
                    OFF: begin
                        if (active) begin
                            state_d = WAKE;
                        end
                    end
                    WAKE: begin
                        state_d = ON;
                    end
                    ON: begin
                        if (!active) begin
                            state_d = HOLD;
                            cnt_d   = cfg_idle_i;
                        end
                    end
                    HOLD: begin
                        if (active) begin
                            state_d = ON;
                        end else if (cnt_q == '0) begin
                            state_d = OFF;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = OFF;
                    end
                endcase
            end

            // Ack tracks the next state so it lands the cycle the channel is ON with req high.
            ack_d = (state_d == ON) & bus.wake_req[g];
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= OFF;
                cnt_q   <= '0;
                ack_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ack_q   <= ack_d;
            end
        end

        assign ack_vec[g]  = ack_q;
        assign gate_vec[g] = gate_open(state_q);

        clk_gate_cell u_gate (
            .clk_i     (clk_i),
            .ena_i     (gate_vec[g]),
            .test_en_i (test_en_i),
            .clk_o     (clk_vec[g])
        );
    end

    assign bus.wake_ack = ack_vec;
    assign bus.gate_en  = gate_vec;
    assign bus.clk_g    = clk_vec;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios followed by random stimulus,
// all compared every cycle against an idle-run-length reference model.
module tb_clk_gate_ctrl;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          test_en  = 1'b0;
    logic [CW-1:0] cfg_idle = '0;

    int errors = 0;
    int checks = 0;

    clk_gate_ctrl_if #(.NUM_CH(NCH)) dif ();

    clk_gate_ctrl #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .test_en_i  (test_en),
        .cfg_idle_i (cfg_idle),
        .bus        (dif)
    );

    always #5 clk = ~clk;

    int edge_cnt [NCH];
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ec
        initial edge_cnt[gi] = 0;
        always @(posedge dif.clk_g[gi]) edge_cnt[gi] = edge_cnt[gi] + 1;
    end

    // Reference model: phase 0=gated, 1=opening, 2=open; idle_run counts consecutive idle open cycles.
    int              m_ph   [NCH];
    int              m_idle [NCH];
    int              m_lim  [NCH];
    logic [NCH-1:0]  m_gate = '0;
    logic [NCH-1:0]  m_ack  = '0;

    task automatic chk(input string tag, input int ch, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s ch%0d: observed=%0d expected=%0d", tag, ch, got, want);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < NCH; i++) begin
            logic act;
            act = dif.busy[i] | dif.wake_req[i];
            if (rst || !dif.ena[i]) begin
                m_ph[i]   = 0;
                m_idle[i] = 0;
            end else if (m_ph[i] == 0) begin
                if (act) m_ph[i] = 1;
            end else if (m_ph[i] == 1) begin
                m_ph[i]   = 2;
                m_idle[i] = 0;
            end else if (act) begin
                m_idle[i] = 0;
            end else begin
                m_idle[i] = m_idle[i] + 1;
                if (m_idle[i] == 1) m_lim[i] = int'(cfg_idle);
                // gate closes after cfg+1 idle cycles following the first idle cycle
                if (m_idle[i] == m_lim[i] + 2) begin
                    m_ph[i]   = 0;
                    m_idle[i] = 0;
                end
            end
            m_gate[i] = (m_ph[i] != 0);
            m_ack[i]  = !rst && (m_ph[i] == 2) && dif.wake_req[i];
        end
    endtask

    // One clock: inputs are already set (clk low); checks at the following negedge.
    task automatic step();
        int             prev [NCH];
        logic [NCH-1:0] exp_rise;
        for (int i = 0; i < NCH; i++) prev[i] = edge_cnt[i];
        exp_rise = m_gate | {NCH{test_en}};
        @(posedge clk);
        model_update();
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            chk("gate_en", i, int'(dif.gate_en[i]), int'(m_gate[i]));
            chk("wake_ack", i, int'(dif.wake_ack[i]), int'(exp_ack_bit(i)));
            chk("clk_edges", i, edge_cnt[i] - prev[i], int'(exp_rise[i]));
        end
        chk("clk_low_phase", 0, int'(dif.clk_g), 0);
    endtask

    function automatic logic exp_ack_bit(input int i);
        return m_ack[i];
    endfunction

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int e0;
        dif.ena      = '0;
        dif.busy     = '0;
        dif.wake_req = '0;
        for (int i = 0; i < NCH; i++) begin
            m_ph[i] = 0; m_idle[i] = 0; m_lim[i] = 0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // reset state
        steps(2);
        chk("reset_gate", 0, int'(dif.gate_en), 0);
        chk("reset_ack", 0, int'(dif.wake_ack), 0);
        rst = 1'b0;

        // ena=0 forces ch0 off despite busy
        dif.ena  = 4'b1110;
        dif.busy = 4'b0001;
        e0 = edge_cnt[0];
        steps(10);
        chk("ena0_no_edges", 0, edge_cnt[0] - e0, 0);
        dif.busy = '0;

        // busy-driven wake and idle hysteresis with cfg_idle=3
        dif.ena  = '1;
        cfg_idle = 8'd3;
        dif.busy[1] = 1'b1;
        steps(5);
        dif.busy[1] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (!dif.gate_en[1]) begin
                lat = n;
                break;
            end
        end
        chk("idle_close_latency", 1, lat, 5);

        // 4-phase wake handshake from OFF
        dif.wake_req[2] = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (dif.wake_ack[2]) begin
                lat = n;
                break;
            end
        end
        chk("wake_ack_latency", 2, lat, 2);
        steps(2);
        dif.wake_req[2] = 1'b0;
        step();
        chk("ack_fall", 2, int'(dif.wake_ack[2]), 0);
        steps(6);

        // cfg_idle=0: busy every other cycle keeps channel open; 2-cycle gaps close it
        cfg_idle = 8'd0;
        for (int k = 0; k < 12; k++) begin
            dif.busy[0] = (k % 2 == 0);
            step();
        end
        for (int k = 0; k < 15; k++) begin
            dif.busy[0] = (k % 3 == 0);
            step();
        end
        dif.busy[0] = 1'b0;
        steps(3);

        // cfg_idle changed mid-count must not affect the running count
        cfg_idle = 8'd5;
        dif.busy[3] = 1'b1;
        steps(3);
        dif.busy[3] = 1'b0;
        step();
        cfg_idle = 8'd1;
        steps(8);

        // test override opens every gate with FSMs off, then releases cleanly
        dif.ena = '0;
        test_en = 1'b1;
        steps(6);
        test_en = 1'b0;
        steps(4);

        // reset with an outstanding ack on ch3 while others are active
        dif.ena = '1;
        cfg_idle = 8'd4;
        dif.busy = 4'b0111;
        dif.wake_req[3] = 1'b1;
        steps(4);
        dif.busy = '0;
        dif.wake_req[3] = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rst_gate", 0, int'(dif.gate_en), 0);
        chk("rst_ack", 3, int'(dif.wake_ack), 0);
        rst = 1'b0;
        steps(2);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NCH; i++) begin
                dif.ena[i]      = ($urandom_range(0, 9) != 0);
                dif.busy[i]     = ($urandom_range(0, 9) < 3);
                dif.wake_req[i] = ($urandom_range(0, 9) < 2);
            end
            cfg_idle = CW'($urandom_range(0, 4));
            test_en  = ($urandom_range(0, 19) == 0);
            rst      = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        test_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
